// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request and issue reservation handshakes
// for the register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 4
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_reg;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_reg;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  rsv_valid;
    logic                  rsv_ready;
    logic [ADDR_WIDTH-1:0] rsv_reg;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_valid, ld_reg, ld_data,
        output rsv_valid, rsv_reg,
        input  alu_ready, ld_ready, rsv_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_valid, ld_reg, ld_data,
        input  rsv_valid, rsv_reg,
        output alu_ready, ld_ready, rsv_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/load arbiter for the regfile write port
// with a busy scoreboard for issue-stage hazard checks.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   wb,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  reg_write,
    output logic [NUM_REGS-1:0]   busy
);
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;

    src_t                last_grant;
    logic                alu_fire;
    logic                ld_fire;
    logic                rsv_fire;
    logic [NUM_REGS-1:0] busy_nxt;

    // On conflict the source that did not win last time is served.
    assign wb.alu_ready = wb.alu_valid &
                          (~wb.ld_valid | (last_grant == SRC_LD));
    assign wb.ld_ready  = wb.ld_valid &
                          (~wb.alu_valid | (last_grant == SRC_ALU));
    assign wb.rsv_ready = wb.rsv_valid & ~busy[wb.rsv_reg];

    assign alu_fire = wb.alu_valid & wb.alu_ready;
    assign ld_fire  = wb.ld_valid & wb.ld_ready;
    assign rsv_fire = wb.rsv_valid & wb.rsv_ready;

    // Clear lands with the regfile commit; a same-reg set overrides it.
    always_comb begin
        busy_nxt = busy;
        if (reg_write) begin
            busy_nxt[write_reg] = 1'b0;
        end
        if (rsv_fire) begin
            busy_nxt[wb.rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_LD;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            busy      <= busy_nxt;
            reg_write <= alu_fire | ld_fire;
            if (alu_fire) begin
                last_grant <= SRC_ALU;
                write_reg  <= wb.alu_reg;
                write_data <= wb.alu_data;
            end else if (ld_fire) begin
                last_grant <= SRC_LD;
                write_reg  <= wb.ld_reg;
                write_data <= wb.ld_data;
            end
        end
    end
endmodule
